// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------+
// | alu_pkg : opcode and FSM state encodings shared by ALU stages       |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SUB  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_bit_slice.sv
// +--------------------------------------------------------------------+
// | alu_bit_slice : one-bit combinational ALU slice built from gates    |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_bit_slice (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       r,
    output logic       cout
);

    logic [2:0] w_nop;
    logic [7:0] w_sel;
    logic [7:0] w_fn;
    logic [7:0] w_term;
    logic       w_and, w_or, w_xor, w_na, w_nor, w_nand;
    logic       w_bb, w_p, w_sum, w_g, w_pc, w_co, w_arith;

    not u_n0 (w_nop[0], op[0]);
    not u_n1 (w_nop[1], op[1]);
    not u_n2 (w_nop[2], op[2]);

    // One-hot opcode decode: each select is a 3-input AND of true/inverted bits
    for (genvar i = 0; i < 8; i++) begin : g_dec
        localparam logic [2:0] C_CODE = 3'(i);
        logic w_d0, w_d1, w_d2;
        assign w_d0 = C_CODE[0] ? op[0] : w_nop[0];
        assign w_d1 = C_CODE[1] ? op[1] : w_nop[1];
        assign w_d2 = C_CODE[2] ? op[2] : w_nop[2];
        and u_sel (w_sel[i], w_d2, w_d1, w_d0);
    end

    and u_and  (w_and,  a, b);
    or  u_or   (w_or,   a, b);
    xor u_xor  (w_xor,  a, b);
    not u_nota (w_na,   a);
    not u_nor  (w_nor,  w_or);
    not u_nand (w_nand, w_and);

    // Subtraction reuses the adder with b inverted; the caller supplies cin=1
    xor u_bb   (w_bb,  b, w_sel[7]);
    xor u_p    (w_p,   a, w_bb);
    xor u_sum  (w_sum, w_p, cin);
    and u_g    (w_g,   a, w_bb);
    and u_pc   (w_pc,  w_p, cin);
    or  u_co   (w_co,  w_g, w_pc);
    or  u_ar   (w_arith, w_sel[6], w_sel[7]);
    and u_cout (cout,  w_co, w_arith);

    assign w_fn = {w_sum, w_sum, w_xor, w_nand, w_nor, w_na, w_or, w_and};

    for (genvar i = 0; i < 8; i++) begin : g_mux
        and u_term (w_term[i], w_sel[i], w_fn[i]);
    end

    assign r = |w_term;

endmodule

`default_nettype wire

// File: rtl/serial_alu.sv
// +--------------------------------------------------------------------+
// | serial_alu : LSB-first bit-serial ALU, one operand bit per clock    |
// | Optional signed-overflow flag: define SERIAL_ALU_OVF_EN             |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
`ifdef SERIAL_ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic             r_cy;

    logic             w_r;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_next;

    alu_bit_slice u_slice (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_cy),
        .op   (r_op),
        .r    (w_r),
        .cout (w_cout)
    );

    // Only the upper WIDTH-1 result bits need storage; the final bit joins at DONE entry
    assign w_res_next = {w_r, r_res};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_AND;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cy    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_cy    <= (op == OP_SUB);
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next[WIDTH-1:1];
                    r_cy  <= w_cout;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        result  <= w_res_next;
                        carry   <= w_cout;
                        zero    <= (w_res_next == '0);
`ifdef SERIAL_ALU_OVF_EN
                        // r_cy still holds the carry into the MSB on this last cycle
                        ovf     <= r_op[2] & r_op[1] & (r_cy ^ w_cout);
`endif
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_alu.sv
// +--------------------------------------------------------------------+
// | tb_serial_alu : directed self-checking bench for serial_alu         |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_serial_alu;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, carry, zero;
    logic [W-1:0] result;
`ifdef SERIAL_ALU_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero)
`ifdef SERIAL_ALU_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cy;
        logic         z;
        logic         ov;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation from IDLE; scramble inputs after capture; return latency and busy count
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int nbusy);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~y; op = ~o;
        lat = -1;
        nbusy = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy) nbusy++;
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, nb, ndone, last_t, hold_err, exp_hold;

        vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{OP_SUB,  8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{OP_SUB,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_XOR,  8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{OP_NAND, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_NOR,  8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{OP_NOT,  8'h3C, 8'h55, 8'hC3, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_OR,   8'h81, 8'h18, 8'h99, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{OP_ADD,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; op = OP_AND; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_done",   32'(done),   32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_carry",  32'(carry),  32'd0);
        chk("reset_zero",   32'(zero),   32'd0);
`ifdef SERIAL_ALU_OVF_EN
        chk("reset_ovf",    32'(ovf),    32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nb);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd9);
            chk($sformatf("v%0d_busy", i),    32'(nb),  32'd9);
            chk($sformatf("v%0d_result", i),  32'(result), 32'(vecs[i].res));
            chk($sformatf("v%0d_carry", i),   32'(carry),  32'(vecs[i].cy));
            chk($sformatf("v%0d_zero", i),    32'(zero),   32'(vecs[i].z));
`ifdef SERIAL_ALU_OVF_EN
            chk($sformatf("v%0d_ovf", i),     32'(ovf),    32'(vecs[i].ov));
`endif
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_hold", i),      32'(result), 32'(vecs[i].res));
        end

        // Start re-asserted mid-RUN with other operands must be ignored
        @(negedge clk);
        op = OP_ADD; a = 8'h7F; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin
                op = OP_SUB; a = 8'h03; b = 8'h05; start = 1'b1;
            end else if (c == 4) begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                chk("ignore_start_result", 32'(result), 32'h80);
                chk("ignore_start_carry",  32'(carry),  32'd0);
            end
            @(negedge clk);
        end
        chk("ignore_start_ndone", 32'(ndone), 32'd1);

        // Reset during the 4th RUN cycle aborts with no done pulse
        @(negedge clk);
        op = OP_ADD; a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_done",   32'(done),   32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_carry",  32'(carry),  32'd0);
        chk("abort_zero",   32'(zero),   32'd0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        do_op(OP_SUB, 8'h10, 8'h01, lat, nb);
        chk("post_abort_latency", 32'(lat),    32'd9);
        chk("post_abort_result",  32'(result), 32'h0F);
        chk("post_abort_carry",   32'(carry),  32'd1);

        // Start held high: one completion every WIDTH+2 cycles, result held between
        @(negedge clk);
        op = OP_ADD; a = 8'h01; b = 8'h02; start = 1'b1;
        ndone = 0; last_t = 0; hold_err = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                exp_hold = (ndone == 1) ? 3 : 6;
                chk($sformatf("b2b_result_%0d", ndone), 32'(result), 32'(exp_hold));
                if (ndone == 1) begin
                    chk("b2b_first_at", 32'(c), 32'd9);
                    b = 8'h05;
                end else begin
                    chk($sformatf("b2b_interval_%0d", ndone), 32'(c - last_t), 32'd10);
                end
                last_t = c;
            end else if (ndone >= 1) begin
                exp_hold = (ndone == 1) ? 3 : 6;
                if (result !== 8'(exp_hold)) hold_err++;
            end
        end
        start = 1'b0;
        chk("b2b_ndone", 32'(ndone), 32'd3);
        chk("b2b_hold",  32'(hold_err), 32'd0);

        repeat (12) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
